marker_pixel_classifier: RTL and testbench

//  Producer of the marker-pixel stream consumed by object recognition.
//  - Scans the incoming YCrCb camera pixels and classifies each pixel into one of 4 marker colours using programmable Cr/Cb windows.
//  - Emits {color, interesting_x, interesting_y, interesting_flag} per qualifying pixel.
//  - Raises frame_flag across vertical blanking so the downstream centroid/corner stage can run its solve.

---
 rtl/marker_pixel_classifier_if.sv | 39 +++
 rtl/marker_pixel_classifier.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_marker_pixel_classifier.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/marker_pixel_classifier_if.sv
// Pixel, configuration and marker-output bundle for marker_pixel_classifier.
interface marker_pixel_classifier_if;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 9;

  logic             pixel_valid;
  logic             pixel_sof;
  logic [PIX_W-1:0] pixel_y;
  logic [PIX_W-1:0] pixel_cr;
  logic [PIX_W-1:0] pixel_cb;

  logic             cfg_we;
  logic [3:0]       cfg_addr;
  logic [PIX_W-1:0] cfg_data;

  logic [1:0]       color;
  logic [X_W-1:0]   interesting_x;
  logic [Y_W-1:0]   interesting_y;
  logic             interesting_flag;
  logic             frame_flag;
  logic             frame_error;

  // Camera/config side: drives pixels and window writes, observes markers.
  modport master (
    output pixel_valid, pixel_sof, pixel_y, pixel_cr, pixel_cb,
    output cfg_we, cfg_addr, cfg_data,
    input  color, interesting_x, interesting_y, interesting_flag,
    input  frame_flag, frame_error
  );

  // Classifier side.
  modport slave (
    input  pixel_valid, pixel_sof, pixel_y, pixel_cr, pixel_cb,
    input  cfg_we, cfg_addr, cfg_data,
    output color, interesting_x, interesting_y, interesting_flag,
    output frame_flag, frame_error
  );
endinterface

// File: rtl/marker_pixel_classifier.sv
// Classifies YCrCb pixels into 4 marker colours with programmable Cr/Cb
// windows, filters short runs, and emits marker pixels plus frame status.
module marker_pixel_classifier #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned Y_MIN    = 16,
  parameter int unsigned RUN_LEN  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  marker_pixel_classifier_if.slave  bus
);

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned XW     = 10;
  localparam int unsigned YW     = 9;
  localparam int unsigned CLR_W  = 2;
  localparam int unsigned NCOL   = 4;
  localparam int unsigned NFLD   = 4;
  localparam int unsigned RUN_W  = 4;

  localparam logic [XW-1:0]    X_LAST  = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0]    Y_LAST  = YW'(V_ACTIVE - 1);
  localparam logic [PIX_W-1:0] Y_FLOOR = PIX_W'(Y_MIN);
  localparam logic [RUN_W-1:0] RUN_CMP = RUN_W'(RUN_LEN);
  localparam logic [RUN_W-1:0] RUN_MAX = '1;

  // Per-colour window: field 0 cr_min, 1 cr_max, 2 cb_min, 3 cb_max.
  typedef logic [NFLD-1:0][PIX_W-1:0] win_t;
  localparam win_t WIN_RST = {8'h00, 8'hFF, 8'h00, 8'hFF};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2,
    S_BLANK  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_drain_cnt;
  logic [1:0]       w_drain_cnt_nxt;

  logic             w_sof_acc;
  logic             w_pix_acc;
  logic             w_premature;
  logic             w_last_pix;
  logic [XW-1:0]    w_pix_x;
  logic [YW-1:0]    w_pix_y;

  logic [XW-1:0]    r_x;
  logic [YW-1:0]    r_y;

  win_t             r_live   [NCOL];
  win_t             r_shadow [NCOL];

  logic             r_s1_valid;
  logic [PIX_W-1:0] r_s1_luma;
  logic [PIX_W-1:0] r_s1_cr;
  logic [PIX_W-1:0] r_s1_cb;
  logic [XW-1:0]    r_s1_x;
  logic [YW-1:0]    r_s1_y;

  logic             w_s1_match;
  logic [CLR_W-1:0] w_s1_color;

  logic             r_s2_valid;
  logic             r_s2_match;
  logic [CLR_W-1:0] r_s2_color;
  logic [XW-1:0]    r_s2_x;
  logic [YW-1:0]    r_s2_y;

  logic [RUN_W-1:0] r_run_cnt;
  logic [CLR_W-1:0] r_run_color;
  logic [YW-1:0]    r_run_y;
  logic [RUN_W-1:0] w_run_cnt_nxt;
  logic             w_run_ext;
  logic             w_emit;

  logic             r_flag;
  logic [CLR_W-1:0] r_color;
  logic [XW-1:0]    r_out_x;
  logic [YW-1:0]    r_out_y;
  logic             r_frame_flag;
  logic             r_frame_error;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  // Next state, pixel acceptance and coordinates of the accepted pixel.
  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    w_sof_acc       = 1'b0;
    w_pix_acc       = 1'b0;
    w_premature     = 1'b0;
    w_pix_x         = r_x;
    w_pix_y         = r_y;
    w_last_pix      = 1'b0;

    if (bus.pixel_valid && bus.pixel_sof) begin
      w_sof_acc   = 1'b1;
      w_pix_acc   = 1'b1;
      w_pix_x     = '0;
      w_pix_y     = '0;
      w_premature = (r_state == S_ACTIVE) || (r_state == S_DRAIN);
      w_state_nxt = S_ACTIVE;
    end else if (bus.pixel_valid && (r_state == S_ACTIVE)) begin
      w_pix_acc = 1'b1;
    end

    w_last_pix = w_pix_acc && (w_pix_x == X_LAST) && (w_pix_y == Y_LAST);

    if (w_last_pix) begin
      w_state_nxt     = S_DRAIN;
      w_drain_cnt_nxt = '0;
    end else if (!w_sof_acc && (r_state == S_DRAIN)) begin
      // Two extra edges after the last pixel lets its flag leave stage 2.
      if (r_drain_cnt == 2'd2) begin
        w_state_nxt = S_BLANK;
      end else begin
        w_drain_cnt_nxt = r_drain_cnt + 2'd1;
      end
    end
  end

  // Raster position of the next pixel; sof forces (0,0) for itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_pix_acc) begin
      if (w_pix_x == X_LAST) begin
        r_x <= '0;
        r_y <= (w_pix_y == Y_LAST) ? '0 : w_pix_y + YW'(1);
      end else begin
        r_x <= w_pix_x + XW'(1);
        r_y <= w_pix_y;
      end
    end
  end

  // Live window bank, writable every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_live <= '{default: WIN_RST};
    end else if (bus.cfg_we) begin
      r_live[bus.cfg_addr[3:2]][bus.cfg_addr[1:0]] <= bus.cfg_data;
    end
  end

  // Shadow bank snapshots the live bank as each frame starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow <= '{default: WIN_RST};
    end else if (w_sof_acc) begin
      r_shadow <= r_live;
    end
  end

  // Stage 1: register accepted pixel and its coordinates.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_luma  <= '0;
      r_s1_cr    <= '0;
      r_s1_cb    <= '0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
    end else begin
      r_s1_valid <= w_pix_acc;
      if (w_pix_acc) begin
        r_s1_luma <= bus.pixel_y;
        r_s1_cr   <= bus.pixel_cr;
        r_s1_cb   <= bus.pixel_cb;
        r_s1_x    <= w_pix_x;
        r_s1_y    <= w_pix_y;
      end
    end
  end

  // Window match against the shadow bank; lowest colour index wins.
  always_comb begin
    w_s1_match = 1'b0;
    w_s1_color = '0;
    for (int k = 0; k < NCOL; k++) begin
      if (!w_s1_match && (r_s1_luma >= Y_FLOOR) &&
          (r_s1_cr >= r_shadow[CLR_W'(k)][0]) && (r_s1_cr <= r_shadow[CLR_W'(k)][1]) &&
          (r_s1_cb >= r_shadow[CLR_W'(k)][2]) && (r_s1_cb <= r_shadow[CLR_W'(k)][3])) begin
        w_s1_match = 1'b1;
        w_s1_color = CLR_W'(k);
      end
    end
  end

  // Stage 2a: register classification; a new frame drops the in-flight pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_match <= 1'b0;
      r_s2_color <= '0;
      r_s2_x     <= '0;
      r_s2_y     <= '0;
    end else begin
      r_s2_valid <= r_s1_valid && !w_sof_acc;
      r_s2_match <= w_s1_match;
      r_s2_color <= w_s1_color;
      r_s2_x     <= r_s1_x;
      r_s2_y     <= r_s1_y;
    end
  end

  // Run filter: same colour on the same line extends, saturating at 15.
  always_comb begin
    w_run_ext     = r_s2_match && (r_run_cnt != '0) &&
                    (r_s2_color == r_run_color) && (r_s2_y == r_run_y);
    w_run_cnt_nxt = r_run_cnt;
    if (r_s2_valid) begin
      if (!r_s2_match) begin
        w_run_cnt_nxt = '0;
      end else if (w_run_ext) begin
        w_run_cnt_nxt = (r_run_cnt == RUN_MAX) ? RUN_MAX : r_run_cnt + RUN_W'(1);
      end else begin
        w_run_cnt_nxt = RUN_W'(1);
      end
    end
    w_emit = r_s2_valid && r_s2_match && (w_run_cnt_nxt >= RUN_CMP) && !w_sof_acc;
  end

  // Stage 2b: run state and registered marker outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_run_cnt   <= '0;
      r_run_color <= '0;
      r_run_y     <= '0;
      r_flag      <= 1'b0;
      r_color     <= '0;
      r_out_x     <= '0;
      r_out_y     <= '0;
    end else begin
      r_flag <= w_emit;
      if (w_sof_acc) begin
        r_run_cnt <= '0;
      end else if (r_s2_valid) begin
        r_run_cnt   <= w_run_cnt_nxt;
        r_run_color <= r_s2_color;
        r_run_y     <= r_s2_y;
      end
      if (w_emit) begin
        r_color <= r_s2_color;
        r_out_x <= r_s2_x;
        r_out_y <= r_s2_y;
      end
    end
  end

  // Frame status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_flag  <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_frame_flag  <= (w_state_nxt == S_BLANK);
      r_frame_error <= w_premature;
    end
  end

  assign bus.interesting_flag = r_flag;
  assign bus.color            = r_color;
  assign bus.interesting_x    = r_out_x;
  assign bus.interesting_y    = r_out_y;
  assign bus.frame_flag       = r_frame_flag;
  assign bus.frame_error      = r_frame_error;

endmodule

// File: tb/tb_marker_pixel_classifier.sv
// Directed bench: a RUN_LEN=1 and a RUN_LEN=3 classifier on one stimulus.
module tb_marker_pixel_classifier;

  localparam int H = 8;
  localparam int V = 4;

  typedef struct {
    int         cyc;
    logic [1:0] color;
    logic [9:0] x;
    logic [8:0] y;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  ev_t  q1[$];
  ev_t  q3[$];
  ev_t  e1;
  ev_t  e3;

  int   cyc_of [V][H];
  int   cfg_at_idx = -1;
  logic [3:0] cfg_at_addr = '0;
  logic [7:0] cfg_at_data = '0;
  logic ff_before_sof;
  logic ff_after_sof;
  logic fe_after_sof;

  marker_pixel_classifier_if bus1 ();
  marker_pixel_classifier_if bus3 ();

  marker_pixel_classifier #(.H_ACTIVE(H), .V_ACTIVE(V), .Y_MIN(16), .RUN_LEN(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1));
  marker_pixel_classifier #(.H_ACTIVE(H), .V_ACTIVE(V), .Y_MIN(16), .RUN_LEN(3)) u_dut3 (
    .clk(clk), .reset(reset), .bus(bus3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Log every emitted marker with the edge count it became visible after.
  always @(negedge clk) begin
    if (bus1.interesting_flag === 1'b1) begin
      e1.cyc = cyc; e1.color = bus1.color; e1.x = bus1.interesting_x; e1.y = bus1.interesting_y;
      q1.push_back(e1);
    end
    if (bus3.interesting_flag === 1'b1) begin
      e3.cyc = cyc; e3.color = bus3.color; e3.x = bus3.interesting_x; e3.y = bus3.interesting_y;
      q3.push_back(e3);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [7:0] yy, input logic [7:0] cr,
                       input logic [7:0] cb);
    bus1.pixel_valid = v; bus1.pixel_sof = s; bus1.pixel_y = yy; bus1.pixel_cr = cr; bus1.pixel_cb = cb;
    bus3.pixel_valid = v; bus3.pixel_sof = s; bus3.pixel_y = yy; bus3.pixel_cr = cr; bus3.pixel_cb = cb;
  endtask

  task automatic drive_cfg(input logic we, input logic [3:0] a, input logic [7:0] d);
    bus1.cfg_we = we; bus1.cfg_addr = a; bus1.cfg_data = d;
    bus3.cfg_we = we; bus3.cfg_addr = a; bus3.cfg_data = d;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
    drive_cfg(1'b1, a, d);
    tick();
    drive_cfg(1'b0, 4'd0, 8'd0);
  endtask

  // Pixel content of each scenario; background never matches any window.
  function automatic void get_pix(input int s, input int x, input int y,
                                  output logic [7:0] py, output logic [7:0] pcr, output logic [7:0] pcb);
    py = 8'd100; pcr = 8'd0; pcb = 8'd0;
    case (s)
      1: if (x == 3 && y == 2) begin pcr = 8'd110; pcb = 8'd55; end
      3: if (y == 1 && x >= 2 && x <= 5) begin pcr = 8'd110; pcb = 8'd55; end
      31: if ((y == 1 && x >= 6) || (y == 2 && x == 0)) begin pcr = 8'd110; pcb = 8'd55; end
      4: begin
        if (x == 3 && y == 2) begin py = 8'd10; pcr = 8'd110; pcb = 8'd55; end
        if (x == 5 && y == 2) begin py = 8'd16; pcr = 8'd120; pcb = 8'd60; end
        if (x == 1 && y == 1) begin pcr = 8'd121; pcb = 8'd55; end
      end
      5: if (x == 1 && (y == 1 || y == 3)) begin pcr = 8'd130; pcb = 8'd55; end
      default: ;
    endcase
  endfunction

  // One full frame, sof on the first pixel, an idle gap after every 5th pixel.
  task automatic send_frame(input int s);
    logic [7:0] py, pcr, pcb;
    int px, pyy;
    q1.delete(); q3.delete();
    for (int i = 0; i < H * V; i++) begin
      px = i % H; pyy = i / H;
      get_pix(s, px, pyy, py, pcr, pcb);
      drive(1'b1, i == 0, py, pcr, pcb);
      if (i == cfg_at_idx) drive_cfg(1'b1, cfg_at_addr, cfg_at_data);
      if (i == 0) ff_before_sof = bus1.frame_flag;
      tick();
      cyc_of[pyy][px] = cyc;
      if (i == 0) begin ff_after_sof = bus1.frame_flag; fe_after_sof = bus1.frame_error; end
      drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
      drive_cfg(1'b0, 4'd0, 8'd0);
      if (i % 5 == 4) tick();
    end
  endtask

  task automatic finish_frame();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    drive_cfg(1'b0, 4'd0, 8'd0);
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    checks++; if (bus1.interesting_flag !== 1'b0) begin errors++; $display("FAIL rst_flag: got %b want 0", bus1.interesting_flag); end
    checks++; if (bus1.color !== 2'd0) begin errors++; $display("FAIL rst_color: got %0d want 0", bus1.color); end
    checks++; if (bus1.interesting_x !== 10'd0) begin errors++; $display("FAIL rst_x: got %0d want 0", bus1.interesting_x); end
    checks++; if (bus1.interesting_y !== 9'd0) begin errors++; $display("FAIL rst_y: got %0d want 0", bus1.interesting_y); end
    checks++; if (bus1.frame_flag !== 1'b0) begin errors++; $display("FAIL rst_frame_flag: got %b want 0", bus1.frame_flag); end
    checks++; if (bus1.frame_error !== 1'b0) begin errors++; $display("FAIL rst_frame_error: got %b want 0", bus1.frame_error); end
    cfg_write(4'd4, 8'd100); cfg_write(4'd5, 8'd120); cfg_write(4'd6, 8'd50); cfg_write(4'd7, 8'd60);
  endtask

  task automatic test_single_marker();
    int k;
    send_frame(1);
    k = cyc_of[V-1][H-1];
    repeat (2) tick();
    checks++; if (bus1.frame_flag !== 1'b0) begin errors++; $display("FAIL t1_ff_early: got %b want 0 at last+2", bus1.frame_flag); end
    tick();
    checks++; if (bus1.frame_flag !== 1'b1) begin errors++; $display("FAIL t1_ff_rise: got %b want 1 at last+3 (last edge %0d)", bus1.frame_flag, k); end
    checks++; if (q1.size() != 1) begin errors++; $display("FAIL t1_count: got %0d want 1", q1.size()); end
    checks++; if (q1.size() < 1 || q1[0].color !== 2'd1) begin errors++; $display("FAIL t1_color: want 1"); end
    checks++; if (q1.size() < 1 || q1[0].x !== 10'd3 || q1[0].y !== 9'd2) begin errors++; $display("FAIL t1_xy: want (3,2)"); end
    checks++; if (q1.size() < 1 || q1[0].cyc != cyc_of[2][3] + 2) begin errors++; $display("FAIL t1_latency: want edge %0d", cyc_of[2][3] + 2); end
  endtask

  task automatic test_priority();
    cfg_write(4'd0, 8'd100); cfg_write(4'd1, 8'd120); cfg_write(4'd2, 8'd50); cfg_write(4'd3, 8'd60);
    cfg_write(4'd8, 8'd105); cfg_write(4'd9, 8'd115); cfg_write(4'd10, 8'd52); cfg_write(4'd11, 8'd58);
    send_frame(1);
    finish_frame();
    checks++; if (ff_before_sof !== 1'b1) begin errors++; $display("FAIL t2_ff_before_sof: got %b want 1", ff_before_sof); end
    checks++; if (ff_after_sof !== 1'b0) begin errors++; $display("FAIL t2_ff_fall: got %b want 0", ff_after_sof); end
    checks++; if (fe_after_sof !== 1'b0) begin errors++; $display("FAIL t2_no_error: got %b want 0", fe_after_sof); end
    checks++; if (q1.size() != 1 || q1[0].color !== 2'd0) begin errors++; $display("FAIL t2_lowest_wins: size %0d want 1 with color 0", q1.size()); end
  endtask

  task automatic test_run_filter();
    send_frame(3);
    finish_frame();
    checks++; if (q3.size() != 2) begin errors++; $display("FAIL t3_run_count: got %0d want 2", q3.size()); end
    checks++; if (q3.size() < 2 || q3[0].x !== 10'd4 || q3[1].x !== 10'd5) begin errors++; $display("FAIL t3_run_x: want 4,5"); end
    checks++; if (q3.size() < 1 || q3[0].y !== 9'd1) begin errors++; $display("FAIL t3_run_y: want 1"); end
    checks++; if (q1.size() != 4) begin errors++; $display("FAIL t3_run1_count: got %0d want 4", q1.size()); end
    send_frame(31);
    finish_frame();
    checks++; if (q3.size() != 0) begin errors++; $display("FAIL t3_line_wrap: got %0d flags want 0", q3.size()); end
    checks++; if (q1.size() != 3) begin errors++; $display("FAIL t3_wrap_run1: got %0d want 3", q1.size()); end
  endtask

  task automatic test_luma_and_edges();
    send_frame(4);
    finish_frame();
    checks++; if (q1.size() != 1) begin errors++; $display("FAIL t4_count: got %0d want 1", q1.size()); end
    checks++; if (q1.size() < 1 || q1[0].x !== 10'd5 || q1[0].y !== 9'd2) begin errors++; $display("FAIL t4_xy: want (5,2)"); end
  endtask

  task automatic test_shadow_config();
    cfg_at_idx = 12; cfg_at_addr = 4'd1; cfg_at_data = 8'd140;
    send_frame(5);
    finish_frame();
    checks++; if (q1.size() != 0) begin errors++; $display("FAIL t5_midframe: got %0d want 0", q1.size()); end
    cfg_at_idx = 0; cfg_at_data = 8'd125;
    send_frame(5);
    finish_frame();
    checks++; if (q1.size() != 2) begin errors++; $display("FAIL t5_next_frame: got %0d want 2", q1.size()); end
    cfg_at_idx = -1;
    send_frame(5);
    finish_frame();
    checks++; if (q1.size() != 0) begin errors++; $display("FAIL t5_sof_write: got %0d want 0", q1.size()); end
  endtask

  task automatic test_premature_sof_and_reset();
    int k, m;
    cfg_write(4'd12, 8'd200); cfg_write(4'd13, 8'd210); cfg_write(4'd14, 8'd200); cfg_write(4'd15, 8'd210);
    q1.delete();
    for (int i = 0; i < 9; i++) begin
      if (i >= 7) drive(1'b1, i == 0, 8'd100, 8'd110, 8'd55);
      else drive(1'b1, i == 0, 8'd100, 8'd0, 8'd0);
      tick();
    end
    drive(1'b1, 1'b1, 8'd100, 8'd110, 8'd55);
    tick(); k = cyc;
    checks++; if (bus1.frame_error !== 1'b1) begin errors++; $display("FAIL t6_err_pulse: got %b want 1", bus1.frame_error); end
    drive(1'b1, 1'b0, 8'd100, 8'd0, 8'd0);
    tick();
    checks++; if (bus1.frame_error !== 1'b0) begin errors++; $display("FAIL t6_err_one_cycle: got %b want 0", bus1.frame_error); end
    drive(1'b1, 1'b0, 8'd100, 8'd205, 8'd205);
    tick(); m = cyc;
    drive(1'b1, 1'b0, 8'd100, 8'd0, 8'd0);
    repeat (2) tick();
    drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    tick();
    checks++; if (q1.size() != 2) begin errors++; $display("FAIL t6_drop_inflight: got %0d flags want 2", q1.size()); end
    checks++; if (q1.size() < 1 || q1[0].x !== 10'd0 || q1[0].y !== 9'd0 || q1[0].cyc != k + 2) begin errors++; $display("FAIL t6_restart_xy: want (0,0) at edge %0d", k + 2); end
    checks++; if (q1.size() < 2 || q1[1].color !== 2'd3 || q1[1].x !== 10'd2 || q1[1].cyc != m + 2) begin errors++; $display("FAIL t6_after_restart: want color 3 x 2 at edge %0d", m + 2); end
    checks++; if (bus1.frame_flag !== 1'b0) begin errors++; $display("FAIL t6_no_frame_flag: got %b want 0", bus1.frame_flag); end
    drive(1'b1, 1'b0, 8'd100, 8'd205, 8'd205);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    checks++; if (bus1.interesting_flag !== 1'b0) begin errors++; $display("FAIL t6_rst_flag: got %b want 0", bus1.interesting_flag); end
    checks++; if (bus1.color !== 2'd0) begin errors++; $display("FAIL t6_rst_color: got %0d want 0", bus1.color); end
    checks++; if (bus1.interesting_x !== 10'd0) begin errors++; $display("FAIL t6_rst_x: got %0d want 0", bus1.interesting_x); end
    checks++; if (bus1.frame_flag !== 1'b0 || bus1.frame_error !== 1'b0) begin errors++; $display("FAIL t6_rst_frame: got %b%b want 00", bus1.frame_flag, bus1.frame_error); end
    q1.delete();
    cfg_write(4'd0, 8'd100); cfg_write(4'd1, 8'd120); cfg_write(4'd2, 8'd50); cfg_write(4'd3, 8'd60);
    drive(1'b1, 1'b0, 8'd100, 8'd110, 8'd55);
    repeat (3) tick();
    drive(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    repeat (3) tick();
    checks++; if (q1.size() != 0) begin errors++; $display("FAIL t6_idle_ignore: got %0d flags want 0", q1.size()); end
    send_frame(1);
    finish_frame();
    checks++; if (q1.size() != 1 || q1[0].color !== 2'd0 || q1[0].x !== 10'd3 || q1[0].y !== 9'd2) begin errors++; $display("FAIL t6_post_reset_frame: size %0d want 1 at (3,2) color 0", q1.size()); end
  endtask

  initial begin
    test_reset();
    test_single_marker();
    test_priority();
    test_run_filter();
    test_luma_and_edges();
    test_shadow_config();
    test_premature_sof_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
